// File: rtl/top_pdp8_panel.sv
// PDP-8 subset processor with a front panel: synchronized buttons and switches,
// a 4K x 12 word memory with per-word valid bits, status LEDs and an octal display.

module top_pdp8_panel (
    input  logic        clk,
    input  logic        btnCpuReset,
    input  logic        btnc,
    input  logic        btnu,
    input  logic        btnd,
    input  logic        btnl,
    input  logic        btnr,
    input  logic [12:0] sw,
    output logic [15:0] led,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    typedef enum logic [2:0] {IDLE, FETCH, EADDR, INDIR, EXEC, WB, HALT} state_t;

    // Bit positions inside the synchronizer vector.
    localparam int BC = 0;
    localparam int BU = 1;
    localparam int BD = 2;
    localparam int BL = 3;
    localparam int BR = 4;
    localparam int SR = 5;

    logic rst;
    assign rst = btnCpuReset;

    logic [5:0] raw_in, sync1_q, sync2_q, sync3_q, rise;
    assign raw_in = {sw[12], btnr, btnl, btnd, btnu, btnc};
    assign rise   = sync2_q & ~sync3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d, ac_q, ac_d, mq_q, mq_d, mb_q, mb_d;
    logic [11:0] ir_q, ir_d, ea_q, ea_d;
    logic        l_q, l_d, run_q, run_d, done_q, done_d, disp_q, disp_d;
    logic [17:0] refresh_q;

    logic [11:0]   mem_q [4096];
    logic [4095:0] valid_q;
    logic          mem_we;
    logic [11:0]   mem_waddr, mem_wdata, mem_raddr, rd_data;

    // Unwritten words read as zero even if the array still holds stale data.
    assign rd_data = valid_q[mem_raddr] ? mem_q[mem_raddr] : 12'o0000;

    // NOTE: the data array has no reset (contents survive btnCpuReset); only valid bits clear.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem_q[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         valid_q <= '0;
        else if (mem_we) valid_q[mem_waddr] <= 1'b1;
    end

    // Group 1 operate microcode applied in sequence to {L,AC}.
    function automatic logic [12:0] group1(input logic [7:0] op, input logic l, input logic [11:0] ac);
        logic [12:0] la;
        la = {l, ac};
        if (op[7]) la[11:0] = 12'o0000;
        if (op[6]) la[12]   = 1'b0;
        if (op[5]) la[11:0] = ~la[11:0];
        if (op[4]) la[12]   = ~la[12];
        if (op[0]) la       = la + 13'd1;
        if (op[3])      la = op[1] ? {la[1:0], la[12:2]} : {la[0], la[12:1]};
        else if (op[2]) la = op[1] ? {la[10:0], la[12:11]} : {la[11:0], la[12]};
        return la;
    endfunction

    // sel = {SMA, SZA, SNL, reverse-sense}
    function automatic logic group2_skip(input logic [3:0] sel, input logic l, input logic [11:0] ac);
        logic any_true;
        any_true = (sel[3] & ac[11]) | (sel[2] & (ac == 12'o0000)) | (sel[1] & l);
        return sel[0] ? !any_true : any_true;
    endfunction

    logic        panel_ok;
    logic [12:0] sum13, la;
    logic [11:0] acc;

    assign panel_ok = !run_q && ((state_q == IDLE) || (state_q == HALT));

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ac_d      = ac_q;
        mq_d      = mq_q;
        mb_d      = mb_q;
        ir_d      = ir_q;
        ea_d      = ea_q;
        l_d       = l_q;
        run_d     = run_q;
        disp_d    = disp_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = ea_q;
        mem_wdata = ac_q;
        mem_raddr = pc_q;
        sum13     = {1'b0, ac_q} + {1'b0, mb_q};
        la        = group1(ir_q[7:0], l_q, ac_q);
        acc       = ir_q[7] ? 12'o0000 : ac_q;

        if (rise[BC]) disp_d = ~disp_q;
        if (rise[SR]) run_d = 1'b1;
        if (!sync2_q[SR]) run_d = 1'b0;

        if (panel_ok) begin
            if (rise[BL]) pc_d = sw[11:0];
            if (rise[BR]) ac_d = sw[11:0];
            if (rise[BD]) begin
                mem_we    = 1'b1;
                mem_waddr = pc_q;
                mem_wdata = sw[11:0];
                pc_d      = pc_q + 12'd1;
            end
        end

        case (state_q)
            IDLE: if (run_q || (panel_ok && rise[BU])) state_d = FETCH;
            FETCH: begin
                ir_d    = rd_data;
                ea_d    = pc_q;           // instruction address, used for its page bits
                pc_d    = pc_q + 12'd1;
                state_d = EADDR;
            end
            EADDR: begin
                ea_d    = ir_q[7] ? {ea_q[11:7], ir_q[6:0]} : {5'b0, ir_q[6:0]};
                state_d = (ir_q[8] && (ir_q[11:9] < 3'd6)) ? INDIR : EXEC;
            end
            INDIR: begin
                mem_raddr = ea_q;
                if (ea_q[11:3] == 9'o001) begin
                    mem_we    = 1'b1;
                    mem_wdata = rd_data + 12'd1;
                    ea_d      = rd_data + 12'd1;
                end else begin
                    ea_d = rd_data;
                end
                state_d = EXEC;
            end
            EXEC: begin
                mem_raddr = ea_q;
                mb_d      = rd_data;
                state_d   = WB;
            end
            WB: begin
                done_d  = 1'b1;
                state_d = IDLE;
                case (ir_q[11:9])
                    3'd0: ac_d = ac_q & mb_q;
                    3'd1: begin
                        ac_d = sum13[11:0];
                        l_d  = l_q ^ sum13[12];
                    end
                    3'd2: begin
                        mem_we    = 1'b1;
                        mem_wdata = mb_q + 12'd1;
                        if (mb_q == 12'o7777) pc_d = pc_q + 12'd1;
                    end
                    3'd3: begin
                        mem_we    = 1'b1;
                        mem_wdata = ac_q;
                        ac_d      = 12'o0000;
                    end
                    3'd4: begin
                        mem_we    = 1'b1;
                        mem_wdata = pc_q;
                        pc_d      = ea_q + 12'd1;
                    end
                    3'd5: pc_d = ea_q;
                    3'd6: begin end
                    default: begin
                        if (!ir_q[8]) begin
                            {l_d, ac_d} = la;
                        end else if (!ir_q[0]) begin
                            if (group2_skip(ir_q[6:3], l_q, ac_q)) pc_d = pc_q + 12'd1;
                            ac_d = acc | (ir_q[2] ? sw[11:0] : 12'o0000);
                            if (ir_q[1]) begin
                                run_d   = 1'b0;
                                state_d = HALT;
                            end
                        end else begin
                            case ({ir_q[6], ir_q[4]})
                                2'b10: ac_d = acc | mq_q;
                                2'b01: begin
                                    mq_d = acc;
                                    ac_d = 12'o0000;
                                end
                                2'b11: begin
                                    mq_d = acc;
                                    ac_d = mq_q;
                                end
                                default: ac_d = acc;
                            endcase
                        end
                    end
                endcase
            end
            HALT: if (rise[SR] || (panel_ok && rise[BU])) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            ac_q      <= '0;
            mq_q      <= '0;
            mb_q      <= '0;
            ir_q      <= '0;
            ea_q      <= '0;
            l_q       <= 1'b0;
            run_q     <= 1'b0;
            done_q    <= 1'b0;
            disp_q    <= 1'b0;
            refresh_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ac_q      <= ac_d;
            mq_q      <= mq_d;
            mb_q      <= mb_d;
            ir_q      <= ir_d;
            ea_q      <= ea_d;
            l_q       <= l_d;
            run_q     <= run_d;
            done_q    <= done_d;
            disp_q    <= disp_d;
            refresh_q <= refresh_q + 18'd1;
        end
    end

    // Octal display: one digit per 2^16 clocks, rightmost digit is the least significant.
    logic [11:0] disp_val;
    logic [2:0]  oct;
    logic [3:0]  an_lo;

    assign disp_val = disp_q ? ac_q : pc_q;

    always_comb begin
        oct   = disp_val[2:0];
        an_lo = 4'b1110;
        case (refresh_q[17:16])
            2'd1: begin oct = disp_val[5:3];  an_lo = 4'b1101; end
            2'd2: begin oct = disp_val[8:6];  an_lo = 4'b1011; end
            2'd3: begin oct = disp_val[11:9]; an_lo = 4'b0111; end
            default: begin end
        endcase
        case (oct)
            3'd0: seg = 7'b1000000;
            3'd1: seg = 7'b1111001;
            3'd2: seg = 7'b0100100;
            3'd3: seg = 7'b0110000;
            3'd4: seg = 7'b0011001;
            3'd5: seg = 7'b0010010;
            3'd6: seg = 7'b0000010;
            default: seg = 7'b1111000;
        endcase
    end

    assign an  = {4'hF, an_lo};
    assign dp  = 1'b1;
    assign led = {1'b0, l_q, done_q, run_q, ac_q};

endmodule

// File: tb/tb_top_pdp8_panel.sv
// Directed bench for top_pdp8_panel: panel operations, short programs, reset abort
// and a table of single-step operate instructions.

module tb_top_pdp8_panel;

    logic        clk = 1'b0;
    logic        rst;
    logic        btnc, btnu, btnd, btnl, btnr;
    logic [12:0] sw;
    logic [15:0] led;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    top_pdp8_panel dut (
        .clk        (clk),
        .btnCpuReset(rst),
        .btnc       (btnc),
        .btnu       (btnu),
        .btnd       (btnd),
        .btnl       (btnl),
        .btnr       (btnr),
        .sw         (sw),
        .led        (led),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    localparam int B_C = 0;
    localparam int B_U = 1;
    localparam int B_D = 2;
    localparam int B_L = 3;
    localparam int B_R = 4;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    task automatic press(input int b);
        @(negedge clk);
        case (b)
            B_C: btnc = 1'b1;
            B_U: btnu = 1'b1;
            B_D: btnd = 1'b1;
            B_L: btnl = 1'b1;
            default: btnr = 1'b1;
        endcase
        repeat (4) @(negedge clk);
        {btnc, btnu, btnd, btnl, btnr} = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic load_pc(input logic [11:0] a);
        sw[11:0] = a;
        press(B_L);
    endtask

    task automatic load_ac(input logic [11:0] v);
        sw[11:0] = v;
        press(B_R);
    endtask

    task automatic deposit(input logic [11:0] d);
        sw[11:0] = d;
        press(B_D);
    endtask

    task automatic step();
        press(B_U);
        repeat (6) @(negedge clk);
    endtask

    // Raise the run switch and wait (bounded) for RUN to rise then fall.
    task automatic run_prog(output int pulses, output bit halted);
        bit saw_run;
        pulses  = 0;
        halted  = 1'b0;
        saw_run = 1'b0;
        sw[12]  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (led[13]) pulses++;
            if (led[12]) saw_run = 1'b1;
            else if (saw_run) begin
                halted = 1'b1;
                break;
            end
        end
        repeat (4) begin
            @(negedge clk);
            if (led[13]) pulses++;
        end
    endtask

    typedef struct {
        logic [11:0] ac_in;
        logic [11:0] pre;
        logic [11:0] instr;
        logic [11:0] exp_ac;
        logic        exp_l;
        logic        exp_skip;
    } vec_t;

    vec_t vecs [19];
    int   pulses;
    bit   halted;

    initial begin
        // {AC in, link-setting pre-instruction, instruction, AC out, L out, skipped}
        vecs[0]  = '{12'o1234, 12'o7100, 12'o7200, 12'o0000, 1'b0, 1'b0}; // CLA
        vecs[1]  = '{12'o1234, 12'o7100, 12'o7040, 12'o6543, 1'b0, 1'b0}; // CMA
        vecs[2]  = '{12'o7777, 12'o7100, 12'o7001, 12'o0000, 1'b1, 1'b0}; // IAC carry
        vecs[3]  = '{12'o0001, 12'o7100, 12'o7010, 12'o0000, 1'b1, 1'b0}; // RAR
        vecs[4]  = '{12'o4000, 12'o7100, 12'o7006, 12'o0001, 1'b0, 1'b0}; // RTL
        vecs[5]  = '{12'o0003, 12'o7120, 12'o7012, 12'o6000, 1'b1, 1'b0}; // RTR
        vecs[6]  = '{12'o0005, 12'o7100, 12'o7041, 12'o7773, 1'b0, 1'b0}; // CIA
        vecs[7]  = '{12'o4000, 12'o7100, 12'o7500, 12'o4000, 1'b0, 1'b1}; // SMA taken
        vecs[8]  = '{12'o0001, 12'o7100, 12'o7440, 12'o0001, 1'b0, 1'b0}; // SZA not taken
        vecs[9]  = '{12'o4000, 12'o7100, 12'o7510, 12'o4000, 1'b0, 1'b0}; // SPA not taken
        vecs[10] = '{12'o0000, 12'o7100, 12'o7410, 12'o0000, 1'b0, 1'b1}; // SKP
        vecs[11] = '{12'o0000, 12'o7100, 12'o7430, 12'o0000, 1'b0, 1'b1}; // SZL taken
        vecs[12] = '{12'o2222, 12'o7120, 12'o7420, 12'o2222, 1'b1, 1'b1}; // SNL taken
        vecs[13] = '{12'o1234, 12'o7100, 12'o7604, 12'o0707, 1'b0, 1'b0}; // CLA OSR
        vecs[14] = '{12'o1010, 12'o7100, 12'o7404, 12'o1717, 1'b0, 1'b0}; // OSR
        vecs[15] = '{12'o1234, 12'o7100, 12'o7421, 12'o0000, 1'b0, 1'b0}; // MQL
        vecs[16] = '{12'o5555, 12'o7120, 12'o7300, 12'o0000, 1'b0, 1'b0}; // CLA CLL
        vecs[17] = '{12'o0000, 12'o7100, 12'o7020, 12'o0000, 1'b1, 1'b0}; // CML
        vecs[18] = '{12'o4000, 12'o7100, 12'o7024, 12'o0001, 1'b1, 1'b0}; // CML RAL

        rst = 1'b1;
        {btnc, btnu, btnd, btnl, btnr} = '0;
        sw = '0;
        repeat (3) @(negedge clk);
        check("reset led", led, 16'h0000);
        check("reset pc", dut.pc_q, 12'o0000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Deposit, then the display (digit 0 still selected this early).
        load_pc(12'o0200);
        deposit(12'o7200);
        check("dep mem", dut.mem_q[12'o0200], 12'o7200);
        check("dep valid", dut.valid_q[12'o0200], 1'b1);
        check("dep pc", dut.pc_q, 12'o0201);
        check("disp an", an, 8'hFE);
        check("disp pc digit", seg, 7'b1111001);
        check("disp dp", dp, 1'b1);
        load_ac(12'o0007);
        press(B_C);
        check("disp ac digit", seg, 7'b1111000);
        check("panel ac", led[11:0], 12'o0007);
        press(B_C);
        check("disp back to pc", seg, 7'b1111001);

        // TAD/DCA program run with the run switch.
        load_pc(12'o0200);
        deposit(12'o7300); deposit(12'o1205); deposit(12'o3206); deposit(12'o7402);
        load_pc(12'o0205);
        deposit(12'o7777);
        load_pc(12'o0200);
        load_ac(12'o1111);
        run_prog(pulses, halted);
        check("tad run halted", halted, 1'b1);
        check("tad done pulses", pulses, 4);
        check("tad mem0206", dut.mem_q[12'o0206], 12'o7777);
        check("tad ac", led[11:0], 12'o0000);
        check("tad link", led[14], 1'b0);
        check("tad pc", dut.pc_q, 12'o0204);
        sw[12] = 1'b0;
        repeat (4) @(negedge clk);

        // ISZ overflow skips the first HLT; HALT must hold while sw[12] stays high.
        load_pc(12'o0300);
        deposit(12'o7777);
        load_pc(12'o0200);
        deposit(12'o2300); deposit(12'o7402); deposit(12'o7402);
        load_pc(12'o0200);
        run_prog(pulses, halted);
        check("isz run halted", halted, 1'b1);
        check("isz mem0300", dut.mem_q[12'o0300], 12'o0000);
        check("isz pc", dut.pc_q, 12'o0203);
        repeat (20) @(negedge clk);
        check("halt holds pc", dut.pc_q, 12'o0203);
        check("halt run low", led[12], 1'b0);
        sw[12] = 1'b0;
        repeat (4) @(negedge clk);

        // JMS single step.
        load_pc(12'o0200);
        deposit(12'o4250);
        load_pc(12'o0200);
        step();
        check("jms mem0250", dut.mem_q[12'o0250], 12'o0201);
        check("jms pc", dut.pc_q, 12'o0251);

        // MQL, SWP, then CLA MQA to read MQ back through AC.
        load_pc(12'o0200);
        deposit(12'o7421); deposit(12'o7521); deposit(12'o7701);
        load_pc(12'o0200);
        load_ac(12'o5670);
        step();
        check("mql ac", led[11:0], 12'o0000);
        load_ac(12'o1234);
        step();
        check("swp ac", led[11:0], 12'o5670);
        step();
        check("swp mq", led[11:0], 12'o1234);

        // Indirect through autoindex location 0010.
        load_pc(12'o0010);
        deposit(12'o0377);
        load_pc(12'o0400);
        deposit(12'o0055);
        load_pc(12'o0200);
        deposit(12'o1410);
        load_pc(12'o0200);
        load_ac(12'o0000);
        step();
        check("autoinc ac", led[11:0], 12'o0055);
        check("autoinc ptr", dut.mem_q[12'o0010], 12'o0400);
        check("autoinc pc", dut.pc_q, 12'o0201);

        // AND then TAD with carry out of bit 11.
        load_pc(12'o0220);
        deposit(12'o0017); deposit(12'o7771);
        load_pc(12'o0200);
        deposit(12'o7100); deposit(12'o0220); deposit(12'o1221);
        load_pc(12'o0200);
        load_ac(12'o7777);
        step();
        step();
        check("and ac", led[11:0], 12'o0017);
        step();
        check("tad carry ac", led[11:0], 12'o0010);
        check("tad carry link", led[14], 1'b1);

        // Reset while a DCA sits in EXEC: five edges after btnu goes high.
        load_pc(12'o0210);
        deposit(12'o1111);
        load_pc(12'o0200);
        deposit(12'o3210);
        load_pc(12'o0200);
        load_ac(12'o5555);
        @(negedge clk);
        btnu = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst  = 1'b1;
        btnu = 1'b0;
        @(negedge clk);
        check("abort led", led, 16'h0000);
        check("abort pc", dut.pc_q, 12'o0000);
        check("abort digit", seg, 7'b1000000);
        repeat (3) @(negedge clk);
        check("abort mem kept", dut.mem_q[12'o0210], 12'o1111);
        check("abort valid clr", dut.valid_q[12'o0210], 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Stale but invalid word must read as zero.
        load_pc(12'o0200);
        deposit(12'o1210);
        load_pc(12'o0200);
        load_ac(12'o0000);
        step();
        check("invalid read", led[11:0], 12'o0000);

        // Single-step operate instruction table.
        for (int i = 0; i < 19; i++) begin
            load_pc(12'o0100);
            deposit(vecs[i].pre);
            deposit(vecs[i].instr);
            load_pc(12'o0100);
            load_ac(vecs[i].ac_in);
            sw[11:0] = 12'o0707;
            step();
            step();
            check($sformatf("vec%0d ac", i), led[11:0], vecs[i].exp_ac);
            check($sformatf("vec%0d link", i), led[14], vecs[i].exp_l);
            check($sformatf("vec%0d pc", i), dut.pc_q, vecs[i].exp_skip ? 12'o0103 : 12'o0102);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/top_pdp8_panel.md
TOP_PDP8_PANEL -- requirements
Module: Top

Interface
REQ-001 SHALL have the following ports:
- clk  in  1  system clock; all state updates on rising edge.
- btnCpuReset  in  1  asynchronous reset, active-high.
- btnc  in  1  display select (toggle on rising edge).
- btnu  in  1  single step.
- btnd  in  1  deposit.
- btnl  in  1  load PC.
- btnr  in  1  load AC.
- sw  in  13  [12] run switch, [11:0] data/address switches.
- led  out  16  [11:0] AC, [12] RUN, [13] instruction-done pulse, [14] Link, [15] 0.
- an  out  8  7-segment anodes, active-low.
- seg  out  7  segments a..g, active-low.
- dp  out  1  decimal point, constant 1 (off).

Function
REQ-002 SHALL pass each button and sw[12] through a 2-flop synchronizer and act on the synchronized rising edge, once per press; no debounce.
REQ-003 SHALL contain a 4096x12 memory with one valid bit per word and a 12-bit PC, AC, MQ, MB, IR, EA, plus a 1-bit Link.
REQ-004 Panel actions SHALL be honoured only while RUN=0:
- btnl: PC<=sw[11:0].
- btnd: mem[PC]<=sw[11:0], valid[PC]<=1, PC<=PC+1 (wraps 7777->0000).
- btnr: AC<=sw[11:0].
- btnu: execute exactly one instruction.
REQ-005 RUN SHALL set on the synchronized rising edge of sw[12]; it SHALL clear on HLT or when sw[12]=0.
REQ-006 CPU FSM states SHALL be IDLE, FETCH, EADDR, INDIR, EXEC, WB, HALT.
- IDLE -> FETCH when RUN=1 or a step is requested.
- FETCH: IR<=mem[PC], PC<=PC+1.
- EADDR: EA = IR[7] ? {PC_old[11:7],IR[6:0]} : {5'b0,IR[6:0]}, where PC_old is the PC of the fetched instruction.
- INDIR: entered only if IR[8]=1; if EA is in 0010-0017, mem[EA]<=mem[EA]+1 first; then EA<=mem[EA].
- EXEC, then WB, then IDLE; HLT goes to HALT.
- Each memory access SHALL take one cycle.
REQ-007 Memory-reference opcodes (IR[11:9]) SHALL behave as:
- 0 AND: AC&=mem[EA].
- 1 TAD: {L,AC}+=mem[EA]; carry out of bit 11 complements L.
- 2 ISZ: mem[EA]+=1; skip (PC+=1) if the result is 0.
- 3 DCA: mem[EA]<=AC, AC<=0.
- 4 JMS: mem[EA]<=PC, PC<=EA+1.
- 5 JMP: PC<=EA.
- 6 IOT: no-op.
REQ-008 Opcode 7 with IR[8]=0 (group 1) SHALL apply, in order:
- CLA (b7), CLL (b6);
- CMA (b5), CML (b4);
- IAC (b0);
- rotate on {L,AC}: RAR (b3) / RAL (b2), by two places if b1=1.
REQ-009 Opcode 7 with IR[8]=1, IR[0]=0 (group 2) SHALL:
- Evaluate skip conditions SMA (b6), SZA (b5), SNL (b4).
- With b3=0, skip if any selected condition is true.
- With b3=1, skip if none is true (SPA/SNA/SZL); 7410 is an unconditional skip.
- After the skip decision, apply CLA (b7), then OSR (b2: AC|=sw[11:0]), then HLT (b1: RUN<=0, enter HALT).
REQ-010 Opcode 7 with IR[8]=1, IR[0]=1 (group 3) SHALL apply CLA (b7), then MQA (b6) and MQL (b4) simultaneously:
- MQA only: AC|=MQ.
- MQL only: MQ<=AC, AC<=0.
- Both (SWP): AC and MQ exchange.
REQ-011 Reads of words with valid=0 SHALL return 0000.
REQ-012 led[13] SHALL pulse high for one cycle on entry to IDLE or HALT after each completed instruction.
REQ-013 led[12] SHALL equal RUN and SHALL fall in the cycle after HLT executes.
REQ-014 The 7-segment display SHALL show 4 octal digits on an[3:0]; an[7:4]=1.
- Shown value is PC when the display toggle is 0, AC when it is 1.
- Digits are multiplexed at clk/2^16.
REQ-015 Leaving HALT SHALL require a new rising edge of sw[12] or btnu.

Reset
REQ-016 While btnCpuReset=1:
- PC, AC, MQ, MB, IR, EA and L SHALL be 0.
- RUN SHALL be 0, the FSM in IDLE, the display toggle 0, and all valid bits 0.
- led SHALL be 16'h0000.
REQ-017 Memory data SHALL NOT be cleared by reset.
REQ-018 Reset asserted mid-instruction SHALL abort the instruction without writing memory.

Verification
REQ-019 Deposit test: btnl with sw=0200, then btnd with sw=7200 -> mem[0200]=7200, valid[0200]=1, PC=0201.
REQ-020 TAD/DCA test:
- mem[0200..0203] = 7300, 1205, 3206, 7402; mem[0205]=7777.
- PC=0200, sw[12]=1.
- Expect mem[0206]=7777, AC=0000, L=0, led[12] falls, PC=0204.
REQ-021 ISZ test: mem[0300]=7777, instruction 2300 -> mem[0300]=0000 and one word skipped.
REQ-022 JMS test: 4250 at 0200 -> mem[0250]=0201, PC=0251.
REQ-023 Group-3 SWP test: AC=1234, MQ=5670, 7521 -> AC=5670, MQ=1234.
REQ-024 Reset test: assert btnCpuReset during EXEC of a DCA -> target word unchanged, PC=0000.
